// File: rtl/bcd_counter_7seg_multi.sv
// Debounced up/down decimal counter (packed BCD, modulo MAX_COUNT) with registered active-low 7-seg decode.
// Step event -> count/wrap +1 cycle -> segments +1 cycle; optional LEADING_ZERO_BLANK_EN blanks leading zeros.
module bcd_counter_7seg_multi #(
  parameter int NUM_DIGITS     = 2,
  parameter int MAX_COUNT      = 100,
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic                    i_Switch_Up,
  input  logic                    i_Switch_Down,
  input  logic                    i_Clear,
  output logic [4*NUM_DIGITS-1:0] o_Count_BCD,
  output logic [7*NUM_DIGITS-1:0] o_Segments,
  output logic                    o_Wrap
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int SW = 7 * NUM_DIGITS;
  localparam int CW = (DEBOUNCE_LIMIT > 2) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [CW-1:0] DB_TOP = CW'(DEBOUNCE_LIMIT - 1);

  function automatic logic [BW-1:0] to_bcd(input int value);
    int v;
    v = value;
    to_bcd = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      to_bcd[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001111;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0000100;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  function automatic logic [SW-1:0] reset_segs(input int digits);
    reset_segs = '0;
    for (int d = 0; d < digits; d++) begin
      reset_segs[7*d +: 7] = 7'b0000001;
`ifdef LEADING_ZERO_BLANK_EN
      if (d > 0) reset_segs[7*d +: 7] = 7'b1111111;
`endif
    end
  endfunction

  localparam logic [BW-1:0] TOP_BCD  = to_bcd(MAX_COUNT - 1);
  localparam logic [SW-1:0] SEG_RST  = reset_segs(NUM_DIGITS);

  // Bit 0 = up button, bit 1 = down button.
  logic [1:0]         raw;
  logic [1:0]         sync_a;
  logic [1:0]         sync_b;
  logic [1:0]         deb;
  logic [1:0]         deb_q;
  logic [1:0][CW-1:0] db_cnt;
  logic               step_up;
  logic               step_dn;

  assign raw = {i_Switch_Down, i_Switch_Up};

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_a <= '0;
      sync_b <= '0;
      deb    <= '0;
      deb_q  <= '0;
      db_cnt <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      deb_q  <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_TOP) begin
          deb[i]    <= sync_b[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign step_up = deb[0] & ~deb_q[0];
  assign step_dn = deb[1] & ~deb_q[1];

  logic [BW-1:0] inc_val;
  logic [BW-1:0] dec_val;

  // Per-digit ripple keeps every digit inside 0..9 without any binary conversion.
  always_comb begin
    logic carry;
    logic borrow;
    inc_val = o_Count_BCD;
    dec_val = o_Count_BCD;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (carry) begin
        if (o_Count_BCD[4*d +: 4] == 4'd9) begin
          inc_val[4*d +: 4] = 4'd0;
        end else begin
          inc_val[4*d +: 4] = o_Count_BCD[4*d +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (o_Count_BCD[4*d +: 4] == 4'd0) begin
          dec_val[4*d +: 4] = 4'd9;
        end else begin
          dec_val[4*d +: 4] = o_Count_BCD[4*d +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Count_BCD <= '0;
      o_Wrap      <= 1'b0;
    end else begin
      o_Wrap <= 1'b0;
      if (i_Clear) begin
        o_Count_BCD <= '0;
      end else if (step_up && !step_dn) begin
        if (o_Count_BCD == TOP_BCD) begin
          o_Count_BCD <= '0;
          o_Wrap      <= 1'b1;
        end else begin
          o_Count_BCD <= inc_val;
        end
      end else if (step_dn && !step_up) begin
        if (o_Count_BCD == '0) begin
          o_Count_BCD <= TOP_BCD;
          o_Wrap      <= 1'b1;
        end else begin
          o_Count_BCD <= dec_val;
        end
      end
    end
  end

  logic [SW-1:0] seg_next;

  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    seg_next = '0;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      seg_next[7*d +: 7] = seg_decode(o_Count_BCD[4*d +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      lead = lead & (o_Count_BCD[4*d +: 4] == 4'd0);
      if (lead && d > 0) seg_next[7*d +: 7] = 7'b1111111;
`endif
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) o_Segments <= SEG_RST;
    else          o_Segments <= seg_next;
  end

endmodule

// File: tb/tb_bcd_counter_7seg_multi.sv
// Bench for bcd_counter_7seg_multi: two instances (modulus 100 and 60) against an integer reference model.
module tb_bcd_counter_7seg_multi;
  localparam int ND = 2;
  localparam int DL = 4;
  localparam int M1 = 100;
  localparam int M2 = 60;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        up = 1'b0;
  logic        dn = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  bcd1, bcd2;
  logic [13:0] seg1, seg2;
  logic        w1, w2;

  always #5 clk = ~clk;

  bcd_counter_7seg_multi #(.NUM_DIGITS(ND), .MAX_COUNT(M1), .DEBOUNCE_LIMIT(DL)) dut1 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch_Up(up), .i_Switch_Down(dn), .i_Clear(clr),
    .o_Count_BCD(bcd1), .o_Segments(seg1), .o_Wrap(w1));

  bcd_counter_7seg_multi #(.NUM_DIGITS(ND), .MAX_COUNT(M2), .DEBOUNCE_LIMIT(DL)) dut2 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch_Up(up), .i_Switch_Down(dn), .i_Clear(clr),
    .o_Count_BCD(bcd2), .o_Segments(seg2), .o_Wrap(w2));

  int n_pass = 0;
  int n_chk  = 0;
  int n_fail = 0;
  int c1 = 0;
  int c2 = 0;
  int wc1 = 0, wc2 = 0, wl1 = 0, wl2 = 0;
  int bw1, bw2, bl1, bl2;
  logic pw1 = 1'b0, pw2 = 1'b0;

  // Wrap pulse monitor: counts pulses and any pulse lasting more than one cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (w1) wc1++;
      if (w1 && pw1) wl1++;
      if (w2) wc2++;
      if (w2 && pw2) wl2++;
      pw1 = w1;
      pw2 = w2;
    end else begin
      pw1 = 1'b0;
      pw2 = 1'b0;
    end
  end

  function automatic logic [7:0] m_bcd(input int v);
    logic [7:0] r;
    int p;
    p = 1;
    r = '0;
    for (int d = 0; d < ND; d++) begin
      r[4*d +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] m_glyph(input int n);
    case (n)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [13:0] m_seg(input int v);
    logic [13:0] r;
    int p;
    p = 1;
    r = '0;
    for (int d = 0; d < ND; d++) begin
      r[7*d +: 7] = m_glyph((v / p) % 10);
`ifdef LEADING_ZERO_BLANK_EN
      if (d > 0 && v < p) r[7*d +: 7] = 7'b1111111;
`endif
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int nxt(input int c, input int dir, input int m);
    return ((c + dir) % m + m) % m;
  endfunction

  function automatic int wraps(input int c, input int dir, input int m);
    return ((dir == 1 && c == m - 1) || (dir == -1 && c == 0)) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    bw1 = wc1; bw2 = wc2; bl1 = wl1; bl2 = wl2;
  endtask

  task automatic check_all(input string tag, input int ew1, input int ew2);
    chk({tag, "_bcd1"}, 32'(bcd1), 32'(m_bcd(c1)));
    chk({tag, "_seg1"}, 32'(seg1), 32'(m_seg(c1)));
    chk({tag, "_bcd2"}, 32'(bcd2), 32'(m_bcd(c2)));
    chk({tag, "_seg2"}, 32'(seg2), 32'(m_seg(c2)));
    chk({tag, "_wrap1"}, 32'(wc1 - bw1), 32'(ew1));
    chk({tag, "_wrap2"}, 32'(wc2 - bw2), 32'(ew2));
    chk({tag, "_wlen"}, 32'((wl1 - bl1) + (wl2 - bl2)), 32'd0);
  endtask

  // kind: 0 up, 1 down, 2 both, 3 up with clear held, 4 short up glitch.
  task automatic op(input string tag, input int kind, input int hold);
    int e1, e2, dir;
    e1 = 0; e2 = 0; dir = 0;
    snap();
    @(posedge clk); #1;
    case (kind)
      0: up = 1'b1;
      1: dn = 1'b1;
      2: begin up = 1'b1; dn = 1'b1; end
      3: begin up = 1'b1; clr = 1'b1; end
      default: up = 1'b1;
    endcase
    repeat (hold) @(posedge clk);
    #1; up = 1'b0; dn = 1'b0;
    repeat (DL + 8) @(posedge clk);
    #1; clr = 1'b0;
    repeat (2) @(posedge clk);
    if (kind == 0) dir = 1;
    if (kind == 1) dir = -1;
    if (dir != 0) begin
      e1 = wraps(c1, dir, M1); c1 = nxt(c1, dir, M1);
      e2 = wraps(c2, dir, M2); c2 = nxt(c2, dir, M2);
    end
    if (kind == 3) begin c1 = 0; c2 = 0; end
    @(negedge clk);
    check_all(tag, e1, e2);
  endtask

  initial begin
    int found;
    logic [13:0] s_old;

    // Asynchronous reset asserted mid-cycle, outputs checked before any clock edge.
    #12 rst_n = 1'b0;
    #1;
    chk("rst_bcd1", 32'(bcd1), 32'h00);
    chk("rst_wrap1", 32'(w1), 32'd0);
    chk("rst_seg1", 32'(seg1), 32'(m_seg(0)));
    chk("rst_bcd2", 32'(bcd2), 32'h00);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    op("glitch2", 4, 2);
    op("down_wrap", 1, DL + 2);
    op("up_wrap", 0, DL + 2);

    // Hold up 10 cycles: exactly one step, segments lag the count by one cycle.
    found = -1;
    s_old = m_seg(c1);
    snap();
    @(posedge clk); #1 up = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (i == 9) up = 1'b0;
      @(negedge clk);
      if (found < 0 && bcd1 !== m_bcd(c1)) begin
        found = i;
        chk("lag_seg_old", 32'(seg1), 32'(s_old));
      end else if (found >= 0 && i == found + 1) begin
        chk("lag_seg_new", 32'(seg1), 32'(m_seg(nxt(c1, 1, M1))));
      end
    end
    chk("step_seen", 32'(found >= 0), 32'd1);
    c1 = nxt(c1, 1, M1);
    c2 = nxt(c2, 1, M2);
    check_all("hold10", 0, 0);

    for (int i = 0; i < 8; i++) op("up_to_9", 0, DL + 1);
    op("carry_10", 0, DL + 3);
    op("both", 2, DL + 2);
    for (int g = 0; g < 60 && c1 != 42; g++) op("nav42", (c1 < 42) ? 0 : 1, DL);
    op("clear_up", 3, DL + 2);
    for (int i = 0; i < 5; i++) op("up_to_5", 0, DL + 1);
`ifdef LEADING_ZERO_BLANK_EN
    chk("blank_d1", 32'(seg1[13:7]), 32'b1111111);
`else
    chk("blank_d1", 32'(seg1[13:7]), 32'b0000001);
`endif
    chk("blank_d0", 32'(seg1[6:0]), 32'b0100100);

    // Reset while the up button is held: a fresh edge only after the debounce window.
    snap();
    @(posedge clk); #1 up = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    c1 = 0; c2 = 0;
    #1 chk("rst_press_bcd1", 32'(bcd1), 32'h00);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    snap();
    repeat (10) @(posedge clk);
    #1 up = 1'b0;
    repeat (DL + 8) @(posedge clk);
    c1 = nxt(c1, 1, M1);
    c2 = nxt(c2, 1, M2);
    @(negedge clk);
    check_all("rst_press", 0, 0);

    for (int i = 0; i < 40; i++) begin
      int kind, hold;
      kind = int'($urandom_range(0, 4));
      hold = (kind == 4) ? int'($urandom_range(1, DL - 1)) : int'($urandom_range(DL, DL + 6));
      op("rand", kind, hold);
    end

    @(posedge clk); #3 rst_n = 1'b0;
    c1 = 0; c2 = 0;
    #1;
    chk("rst2_bcd1", 32'(bcd1), 32'h00);
    chk("rst2_seg1", 32'(seg1), 32'(m_seg(0)));
    chk("rst2_wrap1", 32'(w1), 32'd0);
    chk("rst2_bcd2", 32'(bcd2), 32'h00);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
